nibble_stream_decrypt: RTL and testbench
========================================

Name: nibble_stream_decrypt

Overview:
- Receive-side partner of the team's 4-bit XOR word encryptor. Consumes a ciphertext nibble stream over a valid/ready handshake and emits plaintext over a second valid/ready handshake.
- Applies a rolling key schedule: the key rotates left by 1 after every nibble and reloads at each frame boundary, so it stays in lockstep with the transmit-side encryptor.

Parameters:
- FRAME_LEN, 8, nibbles per frame; legal range 1..256. Key schedule restarts after this many accepted nibbles.
- ROT_EN, 1, 1 = rotate the key left by 1 after each accepted nibble; 0 = static key.

Ports:
- clk  input  1  single clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- key_load  input  1  load pulse for key_in.
- key_in  input  4  frame key.
- cipher_valid  input  1  ciphertext nibble valid.
- cipher_data  input  4  ciphertext nibble.
- cipher_ready  output  1  decryptor can accept a nibble.
- plain_valid  output  1  plaintext nibble valid.
- plain_data  output  4  plaintext nibble.
- plain_ready  input  1  downstream accepts plaintext.
- frame_done  output  1  one-cycle pulse when the last nibble of a frame is accepted.
- busy  output  1  1 while a frame is partially received.

Behaviour:
- Reset (async, rst_n=0): key_reg=0, key_cur=0, cnt=0, state=IDLE. Outputs: cipher_ready=0, plain_valid=0, plain_data=0, frame_done=0, busy=0.
- FSM states:
  - IDLE: no key loaded; cipher_ready=0. key_load moves to READY.
  - READY: key valid, cnt=0.
  - RUN: 0<cnt<FRAME_LEN.
- key_load (any state): key_reg<=key_in, key_cur<=key_in, cnt<=0, state<=READY.
  - In RUN this aborts the frame with no frame_done pulse.
  - A plaintext nibble already held in the output register is kept and still delivered.
  - cipher_ready=0 in any cycle where key_load=1, so key_load wins over accept.
- cipher_ready = (state!=IDLE) && !key_load && (!plain_valid || plain_ready). Single output register, full-throughput pass-through.
- Accept when cipher_valid && cipher_ready:
  - plain_data<=cipher_data ^ key_cur, plain_valid<=1. Latency 1 clock from accept to plain_valid.
  - key_cur<=ROT_EN ? {key_cur[2:0],key_cur[3]} : key_cur.
  - cnt<=cnt+1; state<=RUN.
- Last nibble (accept with cnt==FRAME_LEN-1): cnt<=0, key_cur<=key_reg, state<=READY, frame_done=1 for one cycle (registered, same edge as plain_valid). With FRAME_LEN=1 every accept pulses frame_done.
- plain_valid clears when plain_valid && plain_ready && no new accept in that cycle. Simultaneous drain and accept keeps plain_valid=1 with the new data.
- plain_data and plain_valid hold stable while plain_valid && !plain_ready.
- busy = (state==RUN).
- cnt width = clog2(FRAME_LEN), minimum 1 bit. No wrap beyond FRAME_LEN-1.
- Reset mid-frame: all state clears immediately and any pending plaintext is lost.

Optional Feature:
- Macro: NIBBLE_DECRYPT_PARITY_EN.
- Defined:
  - Adds input cipher_par (1) and output par_err (1, sticky).
  - On each accept, checks cipher_par == ^cipher_data (even parity over the ciphertext). A mismatch sets par_err=1.
  - par_err clears only on reset or key_load. The plaintext is still delivered.
- Undefined: cipher_par and par_err do not exist; no parity logic.

Test Plan:
1. Reset, then key_load with key_in=4'b1010. Send cipher 0110, 0110, 0110 with plain_ready=1 -> plain 1100, 0011, 1100, each 1 cycle after accept; busy=1 after the first accept.
2. FRAME_LEN=8, key 4'b0001, eight cipher nibbles of 0000 -> plain 0001, 0010, 0100, 1000, 0001, 0010, 0100, 1000. frame_done pulses exactly once, on the 8th accept. The 9th nibble 0000 -> plain 0001 (key reloaded).
3. Hold plain_ready=0 with cipher_valid=1 -> after one accept, cipher_ready=0 and plain_data holds stable. Release plain_ready -> back-to-back accepts at 1 nibble per cycle.
4. Mid-frame (cnt=3), key_load with 4'b1111 in the same cycle as cipher_valid=1 -> no accept that cycle, no frame_done. The next cipher 0000 -> plain 1111.
5. Before any key_load, cipher_valid=1 -> cipher_ready stays 0 and plain_valid stays 0. Drop rst_n in RUN with plain_valid=1 -> all outputs 0 asynchronously.
6. (NIBBLE_DECRYPT_PARITY_EN) cipher 0111 with cipher_par=0 -> par_err=1 and stays set across later good nibbles; key_load clears it.

Source files
------------

// File: rtl/nibble_stream_decrypt_if.sv
// Handshake bundle between a nibble ciphertext source, the decryptor and its plaintext sink.
// Parity signals exist only when NIBBLE_DECRYPT_PARITY_EN is defined.
interface nibble_stream_decrypt_if;
  logic       key_load;
  logic [3:0] key_in;
  logic       cipher_valid;
  logic [3:0] cipher_data;
  logic       cipher_ready;
  logic       plain_valid;
  logic [3:0] plain_data;
  logic       plain_ready;
  logic       frame_done;
  logic       busy;
`ifdef NIBBLE_DECRYPT_PARITY_EN
  logic       cipher_par;
  logic       par_err;
`endif

  modport master (
    output key_load, key_in,
    output cipher_valid, cipher_data,
    input  cipher_ready,
    input  plain_valid, plain_data,
    output plain_ready,
    input  frame_done, busy
`ifdef NIBBLE_DECRYPT_PARITY_EN
   ,output cipher_par
   ,input  par_err
`endif
  );

  modport slave (
    input  key_load, key_in,
    input  cipher_valid, cipher_data,
    output cipher_ready,
    output plain_valid, plain_data,
    input  plain_ready,
    output frame_done, busy
`ifdef NIBBLE_DECRYPT_PARITY_EN
   ,input  cipher_par
   ,output par_err
`endif
  );
endinterface

// File: rtl/nibble_stream_decrypt.sv
// Rolling-key XOR nibble stream decryptor, lockstep partner of the 4-bit encryptor.
// Optional even-parity check on ciphertext: define NIBBLE_DECRYPT_PARITY_EN.
module nibble_stream_decrypt #(
  parameter int FRAME_LEN = 8,
  parameter bit ROT_EN    = 1'b1
) (
  input logic clk,
  input logic rst_n,
  nibble_stream_decrypt_if.slave bus
);

  localparam int CW = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
  localparam logic [CW-1:0] LAST = CW'(FRAME_LEN - 1);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] READY = 2'd1;
  localparam logic [1:0] RUN   = 2'd2;

  logic [1:0]    r_state;
  logic [3:0]    r_key_reg;
  logic [3:0]    r_key_cur;
  logic [CW-1:0] r_cnt;
  logic          r_plain_valid;
  logic [3:0]    r_plain_data;
  logic          r_frame_done;

  logic          w_ready;
  logic          w_accept;
  logic          w_last;
  logic [3:0]    w_key_nxt;

  assign w_ready = (r_state != IDLE) && !bus.key_load
                && (!r_plain_valid || bus.plain_ready);
  assign w_accept  = bus.cipher_valid && w_ready;
  assign w_last    = (r_cnt == LAST);
  assign w_key_nxt = ROT_EN ? {r_key_cur[2:0], r_key_cur[3]}
                            : r_key_cur;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= IDLE;
      r_key_reg <= '0;
      r_key_cur <= '0;
      r_cnt     <= '0;
    end else if (bus.key_load) begin
      r_state   <= READY;
      r_key_reg <= bus.key_in;
      r_key_cur <= bus.key_in;
      r_cnt     <= '0;
    end else if (w_accept) begin
      if (w_last) begin
        r_state   <= READY;
        r_key_cur <= r_key_reg;
        r_cnt     <= '0;
      end else begin
        r_state   <= RUN;
        r_key_cur <= w_key_nxt;
        r_cnt     <= r_cnt + CW'(1);
      end
    end
  end

  // Output register: a pending nibble survives key_load and is still delivered.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_plain_valid <= 1'b0;
      r_plain_data  <= '0;
      r_frame_done  <= 1'b0;
    end else begin
      if (w_accept) begin
        r_plain_valid <= 1'b1;
        r_plain_data  <= bus.cipher_data ^ r_key_cur;
      end else if (r_plain_valid && bus.plain_ready) begin
        r_plain_valid <= 1'b0;
      end
      r_frame_done <= w_accept && w_last;
    end
  end

`ifdef NIBBLE_DECRYPT_PARITY_EN
  logic r_par_err;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_par_err <= 1'b0;
    end else if (bus.key_load) begin
      r_par_err <= 1'b0;
    end else if (w_accept && (bus.cipher_par != ^bus.cipher_data)) begin
      r_par_err <= 1'b1;
    end
  end

  assign bus.par_err = r_par_err;
`endif

  assign bus.cipher_ready = w_ready;
  assign bus.plain_valid  = r_plain_valid;
  assign bus.plain_data   = r_plain_data;
  assign bus.frame_done   = r_frame_done;
  assign bus.busy         = (r_state == RUN);

endmodule

// File: tb/tb_nibble_stream_decrypt.sv
// Directed bench for nibble_stream_decrypt (FRAME_LEN=8, ROT_EN=1).
// Inputs change and outputs are sampled on the falling clock edge.
module tb_nibble_stream_decrypt;

  logic clk;
  logic rst_n;
  int   total;
  int   bad;

  nibble_stream_decrypt_if bus ();

  nibble_stream_decrypt #(
    .FRAME_LEN (8),
    .ROT_EN    (1'b1)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [3:0] obs,
                     input logic [3:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  logic [3:0] exp2 [8];

  initial begin
    total = 0;
    bad   = 0;
    exp2  = '{4'b0001, 4'b0010, 4'b0100, 4'b1000,
              4'b0001, 4'b0010, 4'b0100, 4'b1000};
    rst_n = 1'b0;
    bus.key_load     = 1'b0;
    bus.key_in       = 4'b0000;
    bus.cipher_valid = 1'b0;
    bus.cipher_data  = 4'b0000;
    bus.plain_ready  = 1'b0;
`ifdef NIBBLE_DECRYPT_PARITY_EN
    bus.cipher_par   = 1'b0;
`endif

    // reset state
    tick();
    chk("rst_cipher_ready", {3'b0, bus.cipher_ready}, 4'd0);
    chk("rst_plain_valid",  {3'b0, bus.plain_valid},  4'd0);
    chk("rst_plain_data",   bus.plain_data,           4'd0);
    chk("rst_frame_done",   {3'b0, bus.frame_done},   4'd0);
    chk("rst_busy",         {3'b0, bus.busy},         4'd0);
    rst_n = 1'b1;

    // no key yet: nothing accepted
    bus.cipher_valid = 1'b1;
    bus.cipher_data  = 4'b0110;
    bus.plain_ready  = 1'b1;
    tick();
    tick();
    chk("nokey_cipher_ready", {3'b0, bus.cipher_ready}, 4'd0);
    chk("nokey_plain_valid",  {3'b0, bus.plain_valid},  4'd0);

    // basic decrypt with key 1010
    bus.cipher_valid = 1'b0;
    bus.key_load     = 1'b1;
    bus.key_in       = 4'b1010;
    tick();
    chk("t1_busy_ready", {3'b0, bus.busy}, 4'd0);
    bus.key_load     = 1'b0;
    bus.cipher_valid = 1'b1;
    bus.cipher_data  = 4'b0110;
    #1;
    chk("t1_cipher_ready", {3'b0, bus.cipher_ready}, 4'd1);
    tick();
    chk("t1_pv0", {3'b0, bus.plain_valid}, 4'd1);
    chk("t1_pd0", bus.plain_data, 4'b1100);
    chk("t1_busy", {3'b0, bus.busy}, 4'd1);
    tick();
    chk("t1_pd1", bus.plain_data, 4'b0011);
    tick();
    chk("t1_pd2", bus.plain_data, 4'b1100);

    // key_load at cnt=3 collides with cipher_valid
    bus.key_load = 1'b1;
    bus.key_in   = 4'b1111;
    #1;
    chk("t4_ready_blocked", {3'b0, bus.cipher_ready}, 4'd0);
    tick();
    chk("t4_pv_drained", {3'b0, bus.plain_valid}, 4'd0);
    chk("t4_frame_done", {3'b0, bus.frame_done},  4'd0);
    chk("t4_busy",       {3'b0, bus.busy},        4'd0);
    bus.key_load    = 1'b0;
    bus.cipher_data = 4'b0000;
    tick();
    chk("t4_pv",  {3'b0, bus.plain_valid}, 4'd1);
    chk("t4_pd",  bus.plain_data, 4'b1111);
    bus.cipher_valid = 1'b0;

    // full frame with key 0001
    bus.key_load = 1'b1;
    bus.key_in   = 4'b0001;
    tick();
    bus.key_load     = 1'b0;
    bus.cipher_valid = 1'b1;
    bus.cipher_data  = 4'b0000;
    for (int i = 0; i < 8; i++) begin
      tick();
      chk($sformatf("t2_pd%0d", i), bus.plain_data, exp2[i]);
      chk($sformatf("t2_fd%0d", i), {3'b0, bus.frame_done},
          (i == 7) ? 4'd1 : 4'd0);
    end
    chk("t2_busy_end", {3'b0, bus.busy}, 4'd0);
    tick();
    chk("t2_pd_reload", bus.plain_data, 4'b0001);
    chk("t2_fd_after",  {3'b0, bus.frame_done}, 4'd0);
    bus.cipher_valid = 1'b0;
    tick();
    chk("t2_pv_drain", {3'b0, bus.plain_valid}, 4'd0);

    // backpressure with key 0011
    bus.key_load = 1'b1;
    bus.key_in   = 4'b0011;
    tick();
    bus.key_load     = 1'b0;
    bus.plain_ready  = 1'b0;
    bus.cipher_valid = 1'b1;
    bus.cipher_data  = 4'b0101;
    tick();
    chk("t3_pv",        {3'b0, bus.plain_valid},  4'd1);
    chk("t3_pd",        bus.plain_data,           4'b0110);
    chk("t3_ready_low", {3'b0, bus.cipher_ready}, 4'd0);
    bus.cipher_data = 4'b1001;
    tick();
    chk("t3_pd_hold", bus.plain_data,          4'b0110);
    chk("t3_pv_hold", {3'b0, bus.plain_valid}, 4'd1);
    bus.plain_ready = 1'b1;
    #1;
    chk("t3_ready_high", {3'b0, bus.cipher_ready}, 4'd1);
    tick();
    chk("t3_pd_b2b0", bus.plain_data, 4'b1111);
    bus.cipher_data = 4'b0000;
    tick();
    chk("t3_pd_b2b1", bus.plain_data, 4'b1100);

    // asynchronous reset mid-frame with plaintext pending
    bus.cipher_valid = 1'b0;
    bus.plain_ready  = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    chk("ar_plain_valid",  {3'b0, bus.plain_valid},  4'd0);
    chk("ar_plain_data",   bus.plain_data,           4'd0);
    chk("ar_cipher_ready", {3'b0, bus.cipher_ready}, 4'd0);
    chk("ar_busy",         {3'b0, bus.busy},         4'd0);
    chk("ar_frame_done",   {3'b0, bus.frame_done},   4'd0);
    tick();
    rst_n = 1'b1;

`ifdef NIBBLE_DECRYPT_PARITY_EN
    chk("par_rst", {3'b0, bus.par_err}, 4'd0);
    bus.key_load = 1'b1;
    bus.key_in   = 4'b0000;
    tick();
    bus.key_load     = 1'b0;
    bus.plain_ready  = 1'b1;
    bus.cipher_valid = 1'b1;
    bus.cipher_data  = 4'b0111;
    bus.cipher_par   = 1'b0;
    tick();
    chk("par_set",    {3'b0, bus.par_err}, 4'd1);
    chk("par_pd",     bus.plain_data,      4'b0111);
    bus.cipher_data = 4'b0001;
    bus.cipher_par  = 1'b1;
    tick();
    chk("par_sticky", {3'b0, bus.par_err}, 4'd1);
    chk("par_pd2",    bus.plain_data,      4'b0001);
    bus.cipher_valid = 1'b0;
    bus.key_load     = 1'b1;
    tick();
    chk("par_clear",  {3'b0, bus.par_err}, 4'd0);
    bus.key_load = 1'b0;
`endif

    tick();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
